riscv_dmem_resp: RTL and testbench
==================================

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, RAM size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, RAM base byte address.
REQ-003 SHALL have parameter SERIAL_ADDR, default 32'ha000_03f8: TX data register; status register at +4.
REQ-004 SHALL have parameter RTC_ADDR, default 32'ha000_0048: timer low word; high word at +4.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-008 SHALL have ports memop in 3 (access type), memdata in 32 (store data), mem_wen in 1 (store strobe), mem_addr in 32 (byte address).
REQ-009 SHALL have port mem_data  out  32  load data, combinational from the current request.
REQ-010 SHALL have ports tx_data out 8, tx_valid out 1, tx_ready in 1 (serial drain handshake).
REQ-011 SHALL have ports bus_err out 1 (registered pulse), err_addr out 32 (address of last faulting access).

Function
REQ-012 memop SHALL decode as: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores use size only (000/001/010).
REQ-013 Loads SHALL be combinational: mem_data valid in the same cycle as mem_addr/memop, so a single-cycle core can write it back.
REQ-014 Load data SHALL be the addressed lane, right-justified; sign- or zero-extended per memop.
REQ-015 Stores SHALL commit at the rising edge while mem_wen=1, writing only the addressed byte lanes (sb 1, sh 2, sw 4).
REQ-016 A store followed by a load of the same address on the next cycle SHALL return the new data.
REQ-017 Misaligned accesses (half at offset 3, word at nonzero offset), out-of-map addresses and illegal memop (011, 110, 111) SHALL be faults.
REQ-018 On a fault: mem_data=0, no state change, bus_err=1 for exactly the next cycle, err_addr updated to mem_addr at that edge.
REQ-019 A store of any size to SERIAL_ADDR SHALL push memdata[7:0] into the TX FIFO.
REQ-020 A push while the FIFO is full SHALL be dropped and set the sticky flag ovf; exception: a push coinciding with a pop (tx_valid&tx_ready) SHALL be accepted.
REQ-021 tx_valid SHALL equal FIFO non-empty; tx_data SHALL be the head entry; the head SHALL advance on the edge where tx_valid&tx_ready.
REQ-022 A load at SERIAL_ADDR+4 SHALL return {ovf at bit 31, count at bits 15:8, full at bit 1, empty at bit 0}; stores there SHALL clear ovf. A load at SERIAL_ADDR SHALL return 0.
REQ-023 The 64-bit cycle counter SHALL increment every non-reset cycle and wrap from all-ones to 0.
REQ-024 A load at RTC_ADDR SHALL return counter[31:0] and snapshot counter[63:32] at that edge; a load at RTC_ADDR+4 SHALL return the snapshot. RTC stores SHALL be ignored without fault.
REQ-025 Pointer and count arithmetic SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 While rst=1: FIFO empty, tx_valid=0, ovf=0, counter=0, snapshot=0, bus_err=0, err_addr=0; stores are suppressed.
REQ-027 Reset SHALL NOT clear RAM contents; reset mid-drain SHALL discard all FIFO entries.

Configuration
REQ-028 With macro DMEM_RTC_EN defined, REQ-023/024 SHALL apply. Without it, counter and snapshot SHALL be absent, RTC loads SHALL return 0, and RTC accesses SHALL NOT fault.

Verification
REQ-029 sw 32'h8765_43a1 at BASE_ADDR, then lb/lbu/lh/lhu/lw at BASE_ADDR -> ffff_ffa1, 0000_00a1, 0000_43a1, 0000_43a1, 8765_43a1.
REQ-030 sh 16'hbeef at BASE_ADDR+2 over word 0 -> lw returns beef_43a1; lh at BASE_ADDR+3 -> bus_err pulse next cycle, err_addr=BASE_ADDR+3, RAM unchanged.
REQ-031 tx_ready=0, 9 sb to SERIAL_ADDR (0x41..0x49) -> status=8000_0802; raise tx_ready -> 0x41..0x48 drained in order, one per cycle, then tx_valid=0.
REQ-032 FIFO full with tx_ready=1, same-cycle push 0x5a -> accepted, ovf stays 0, 0x5a is the last byte out.
REQ-033 DMEM_RTC_EN defined, 100 cycles after reset release -> RTC_ADDR load returns 100 (±1 cycle per bench convention), RTC_ADDR+4 load returns 0; rst asserted mid-drain -> tx_valid=0 next cycle.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// ---------------------------------------------------------------------------
// riscv_dmem_resp
//
// Data-memory responder for a single-cycle RISC-V core. It provides:
//   * a byte-lane RAM of DEPTH_WORDS 32-bit words at BASE_ADDR. Loads are
//     combinational and stores commit on the rising edge.
//   * a serial TX port. Any store to SERIAL_ADDR pushes one byte into a
//     FIFO, and the FIFO drains over a valid/ready handshake. A status word
//     sits at SERIAL_ADDR+4.
//   * an optional 64-bit cycle counter (RTC) at RTC_ADDR / RTC_ADDR+4.
//     It is enabled by defining the macro DMEM_RTC_EN. Without the macro
//     the RTC addresses still decode (no fault) but read as zero.
//
// Every cycle is treated as an access: a store when mem_wen=1, otherwise a
// load of mem_addr. Faults are illegal memop, misalignment and unmapped
// addresses. A faulting access changes no state, reads 0, and raises
// bus_err for one cycle.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   memop     in   3   access type: {unsigned, size[1:0]}
//   memdata   in  32   store data (right-justified)
//   mem_wen   in   1   store strobe
//   mem_addr  in  32   byte address
//   mem_data  out 32   load data, combinational from the current request
//   tx_data   out  8   FIFO head byte
//   tx_valid  out  1   FIFO non-empty
//   tx_ready  in   1   sink accepts tx_data this cycle
//   bus_err   out  1   one-cycle pulse after a faulting access
//   err_addr  out 32   address of the most recent faulting access
// ---------------------------------------------------------------------------
module riscv_dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] SERIAL_ADDR = 32'ha000_03f8,
    parameter logic [31:0] RTC_ADDR    = 32'ha000_0048,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  memop,
    input  logic [31:0] memdata,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [32:0] RAM_BYTES        = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [31:0] SERIAL_STAT_ADDR = SERIAL_ADDR + 32'd4;
    localparam logic [31:0] RTC_HI_ADDR      = RTC_ADDR + 32'd4;

    // -----------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------
    logic [1:0]    byte_off;
    logic [1:0]    size;
    logic          illegal_op;
    logic          misaligned;
    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    logic          in_ram;
    logic          ser_data_hit;
    logic          ser_stat_hit;
    logic          rtc_lo_hit;
    logic          rtc_hi_hit;
    logic          fault;
    logic          access_ok;

    assign byte_off   = mem_addr[1:0];
    assign size       = memop[1:0];
    assign illegal_op = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111);
    // Halfwords may straddle lanes 1..2; only offset 3 leaves the word.
    assign misaligned = ((size == 2'b01) && (byte_off == 2'b11)) ||
                        ((size == 2'b10) && (byte_off != 2'b00));

    // Subtracting the base makes addresses below BASE_ADDR wrap to large
    // values, so a single unsigned compare covers both ends of the window.
    assign ram_off = mem_addr - BASE_ADDR;
    assign ram_idx = ram_off[AW+1:2];
    assign in_ram  = ({1'b0, ram_off} < RAM_BYTES);

    assign ser_data_hit = (mem_addr[31:2] == SERIAL_ADDR[31:2]);
    assign ser_stat_hit = (mem_addr[31:2] == SERIAL_STAT_ADDR[31:2]);
    assign rtc_lo_hit   = (mem_addr[31:2] == RTC_ADDR[31:2]);
    assign rtc_hi_hit   = (mem_addr[31:2] == RTC_HI_ADDR[31:2]);

    assign fault = illegal_op || misaligned ||
                   !(in_ram || ser_data_hit || ser_stat_hit || rtc_lo_hit || rtc_hi_hit);
    assign access_ok = !fault && !rst;

    // -----------------------------------------------------------------
    // Store datapath: lane enables and lane-aligned write data
    // -----------------------------------------------------------------
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        ram_we;

    always_comb begin
        byte_en = 4'b1111;
        case (size)
            2'b00:   byte_en = 4'b0001 << byte_off;
            2'b01:   byte_en = 4'b0011 << byte_off;
            default: byte_en = 4'b1111;
        endcase
    end

    assign wdata  = memdata << {byte_off, 3'b000};
    assign ram_we = access_ok && mem_wen && in_ram;

    // One array per byte lane, so each lane has a single writer and
    // partial stores need no read-modify-write.
    logic [31:0] ram_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (ram_we && byte_en[gi]) begin
                    lane_mem[ram_idx] <= wdata[8*gi +: 8];
                end
            end

            assign ram_word[8*gi +: 8] = lane_mem[ram_idx];
        end
    endgenerate

    // -----------------------------------------------------------------
    // TX FIFO
    // -----------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ovf_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          push_drop;
    logic          ovf_clr;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign tx_valid   = !fifo_empty && !rst;
    assign tx_data    = fifo_mem[rd_ptr_reg];
    assign pop        = tx_valid && tx_ready;

    assign push_req  = access_ok && mem_wen && ser_data_hit;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;
    assign ovf_clr   = access_ok && mem_wen && ser_stat_hit;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end else if (push_drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= memdata[7:0];
        end
    end

    logic [31:0] status_word;
    assign status_word = {ovf_reg, 15'b0, 8'(count_reg), 6'b0, fifo_full, fifo_empty};

    // -----------------------------------------------------------------
    // Cycle counter
    // -----------------------------------------------------------------
    logic [31:0] rtc_lo_word;
    logic [31:0] rtc_hi_word;

`ifdef DMEM_RTC_EN
    logic [63:0] counter_reg;
    logic [31:0] snap_reg;
    logic        rtc_snap;

    // Reading the low word latches the high word, so a low/high read pair
    // forms one coherent 64-bit sample.
    assign rtc_snap = access_ok && !mem_wen && rtc_lo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg <= '0;
            snap_reg    <= '0;
        end else begin
            counter_reg <= counter_reg + 64'd1;
            if (rtc_snap) begin
                snap_reg <= counter_reg[63:32];
            end
        end
    end

    assign rtc_lo_word = counter_reg[31:0];
    assign rtc_hi_word = snap_reg;
`else
    assign rtc_lo_word = '0;
    assign rtc_hi_word = '0;
`endif

    // -----------------------------------------------------------------
    // Load datapath: select the source word, then extract the lane
    // -----------------------------------------------------------------
    logic [31:0] rd_word;
    logic [15:0] lane16;
    logic [31:0] load_val;

    always_comb begin
        rd_word = '0;
        if (in_ram) begin
            rd_word = ram_word;
        end else if (ser_stat_hit) begin
            rd_word = status_word;
        end else if (rtc_lo_hit) begin
            rd_word = rtc_lo_word;
        end else if (rtc_hi_hit) begin
            rd_word = rtc_hi_word;
        end
    end

    assign lane16 = 16'(rd_word >> {byte_off, 3'b000});

    always_comb begin
        load_val = '0;
        case (memop)
            3'b000:  load_val = {{24{lane16[7]}}, lane16[7:0]};
            3'b001:  load_val = {{16{lane16[15]}}, lane16};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'b0, lane16[7:0]};
            3'b101:  load_val = {16'b0, lane16};
            default: load_val = '0;
        endcase
    end

    assign mem_data = fault ? 32'b0 : load_val;

    // -----------------------------------------------------------------
    // Fault reporting
    // -----------------------------------------------------------------
    logic        bus_err_reg;
    logic [31:0] err_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_reg  <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            bus_err_reg <= fault;
            if (fault) begin
                err_addr_reg <= mem_addr;
            end
        end
    end

    assign bus_err  = bus_err_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_riscv_dmem_resp
//
// Scoreboard bench for riscv_dmem_resp. The stimulus process drives one
// request per cycle and queues the expected responses:
//   chk_q - signal values due at this cycle's falling edge
//   tx_q  - bytes in the order they must leave the TX port
//   err_q - bus_err pulses, each tagged with the cycle it is due in
// The monitor process samples the DUT on every falling edge, drains those
// queues and keeps the counters.
// ---------------------------------------------------------------------------
module tb_riscv_dmem_resp;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] SERIAL = 32'ha000_03f8;
    localparam logic [31:0] RTC    = 32'ha000_0048;
    localparam logic [31:0] RAM_SZ = 32'h0000_4000;

    localparam int SEL_DATA   = 0;
    localparam int SEL_TXV    = 1;
    localparam int SEL_BUSERR = 2;
    localparam int SEL_ERRADR = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  memop;
    logic [31:0] memdata;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_err;
    logic [31:0] err_addr;

    riscv_dmem_resp #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (BASE),
        .SERIAL_ADDR (SERIAL),
        .RTC_ADDR    (RTC),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memop    (memop),
        .memdata  (memdata),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          sel;
        int          due;
    } exp_t;

    exp_t chk_q[$];
    exp_t tx_q[$];
    exp_t err_q[$];

    int cyc;
    int n_cmp;
    int n_bad;
    bit done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] act;
        while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            case (e.sel)
                SEL_DATA:   act = mem_data;
                SEL_TXV:    act = {31'b0, tx_valid};
                SEL_BUSERR: act = {31'b0, bus_err};
                default:    act = err_addr;
            endcase
            compare(e.name, act, e.val);
            $display("[%0d] check %s = %h", cyc, e.name, act);
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() > 0) begin
                e = tx_q.pop_front();
                compare(e.name, {24'b0, tx_data}, e.val);
                $display("[%0d] tx %s byte %h", cyc, e.name, tx_data);
            end else begin
                compare("tx_unexpected_valid", {31'b0, tx_valid}, 32'd0);
            end
        end
        if (err_q.size() > 0 && err_q[0].due == cyc) begin
            e = err_q.pop_front();
            compare({e.name, "_pulse"}, {31'b0, bus_err}, 32'd1);
            compare({e.name, "_addr"}, err_addr, e.val);
            $display("[%0d] bus_err %s addr %h", cyc, e.name, err_addr);
        end else begin
            compare("bus_err_idle", {31'b0, bus_err}, 32'd0);
        end
        if (done) begin
            compare("tx_leftover", 32'(tx_q.size()), 32'd0);
            compare("err_leftover", 32'(err_q.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected end before 100000");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_wen  = 1'b0;
        memop    = 3'b010;
        mem_addr = BASE;
        memdata  = '0;
    endtask

    task automatic expect_sig(input string nm, input int sel, input logic [31:0] v);
        chk_q.push_back('{nm, v, sel, cyc});
    endtask

    task automatic expect_err(input string nm, input logic [31:0] a);
        err_q.push_back('{nm, a, SEL_ERRADR, cyc + 1});
    endtask

    task automatic expect_tx(input string nm, input logic [7:0] b);
        tx_q.push_back('{nm, {24'b0, b}, 0, 0});
    endtask

    task automatic store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        mem_wen  = 1'b1;
        memop    = op;
        mem_addr = a;
        memdata  = d;
        step();
        idle();
    endtask

    task automatic load(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] exp);
        mem_wen  = 1'b0;
        memop    = op;
        mem_addr = a;
        expect_sig(nm, SEL_DATA, exp);
        step();
        idle();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rtc_exp;

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        done     = 1'b0;
        idle();
        repeat (3) step();

        // reset state
        expect_sig("rst_tx_valid", SEL_TXV, 32'd0);
        expect_sig("rst_bus_err", SEL_BUSERR, 32'd0);
        expect_sig("rst_err_addr", SEL_ERRADR, 32'd0);
        load("rst_status", 3'b010, SERIAL + 32'd4, 32'h0000_0001);

        // counter starts from zero at release and counts every cycle
        rst = 1'b0;
        load("rtc_lo_at_release", 3'b010, RTC, 32'd0);
        repeat (99) step();
`ifdef DMEM_RTC_EN
        rtc_exp = 32'd100;
`else
        rtc_exp = 32'd0;
`endif
        load("rtc_lo_100", 3'b010, RTC, rtc_exp);
        load("rtc_hi_snap", 3'b010, RTC + 32'd4, 32'd0);
        store(3'b010, RTC, 32'h1234_5678);

        // lane extraction and extension
        store(3'b010, BASE + 32'd8, 32'h1111_1111);
        store(3'b010, BASE, 32'h8765_43a1);
        load("lb", 3'b000, BASE, 32'hffff_ffa1);
        load("lbu", 3'b100, BASE, 32'h0000_00a1);
        load("lh", 3'b001, BASE, 32'h0000_43a1);
        load("lhu", 3'b101, BASE, 32'h0000_43a1);
        load("lw", 3'b010, BASE, 32'h8765_43a1);

        // partial stores, straddling half, faults
        store(3'b001, BASE + 32'd2, 32'h0000_beef);
        load("lw_after_sh", 3'b010, BASE, 32'hbeef_43a1);
        load("lhu_off1", 3'b101, BASE + 32'd1, 32'h0000_ef43);
        load("lb_off3", 3'b000, BASE + 32'd3, 32'hffff_ffbe);
        expect_err("err_lh3", BASE + 32'd3);
        load("lh3_data", 3'b001, BASE + 32'd3, 32'd0);
        load("lw_after_lh3", 3'b010, BASE, 32'hbeef_43a1);
        expect_err("err_sw1", BASE + 32'd1);
        store(3'b010, BASE + 32'd1, 32'hffff_ffff);
        load("lw_after_sw1", 3'b010, BASE, 32'hbeef_43a1);
        expect_err("err_unmapped", 32'h0000_0010);
        load("unmapped_data", 3'b010, 32'h0000_0010, 32'd0);
        step();
        expect_err("err_op011", BASE);
        load("op011_data", 3'b011, BASE, 32'd0);
        step();
        expect_sig("err_addr_hold", SEL_ERRADR, BASE);
        store(3'b010, BASE + RAM_SZ - 32'd4, 32'h0bad_f00d);
        load("lw_ram_top", 3'b010, BASE + RAM_SZ - 32'd4, 32'h0bad_f00d);
        expect_err("err_ram_end", BASE + RAM_SZ);
        load("ram_end_data", 3'b010, BASE + RAM_SZ, 32'd0);
        step();

        // FIFO fill past full, then drain
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_tx("drain", 8'(8'h41 + i));
            store(3'b000, SERIAL, 32'(8'h41 + i));
        end
        load("status_ovf_full", 3'b010, SERIAL + 32'd4, 32'h8000_0802);
        load("serial_data_read", 3'b010, SERIAL, 32'd0);
        tx_ready = 1'b1;
        repeat (8) step();
        expect_sig("drained_tx_valid", SEL_TXV, 32'd0);
        load("status_drained", 3'b010, SERIAL + 32'd4, 32'h8000_0001);
        store(3'b010, SERIAL + 32'd4, 32'd0);
        load("status_ovf_clr", 3'b010, SERIAL + 32'd4, 32'h0000_0001);

        // push into a full FIFO in the same cycle as a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_tx("full_pop", 8'(8'h50 + i));
            store(3'b000, SERIAL, 32'(8'h50 + i));
        end
        load("status_full", 3'b010, SERIAL + 32'd4, 32'h0000_0802);
        tx_ready = 1'b1;
        expect_tx("same_cycle_push", 8'h5a);
        store(3'b000, SERIAL, 32'h0000_005a);
        load("status_push_pop", 3'b010, SERIAL + 32'd4, 32'h0000_0802);
        repeat (7) step();
        load("status_no_ovf", 3'b010, SERIAL + 32'd4, 32'h0000_0001);

        // reset in the middle of a drain
        tx_ready = 1'b0;
        expect_tx("pre_reset", 8'h61);
        store(3'b000, SERIAL, 32'h0000_0061);
        store(3'b000, SERIAL, 32'h0000_0062);
        store(3'b000, SERIAL, 32'h0000_0063);
        tx_ready = 1'b1;
        step();
        rst = 1'b1;
        store(3'b010, BASE + 32'd8, 32'hdead_beef);
        expect_sig("rst_mid_tx_valid", SEL_TXV, 32'd0);
        step();
        rst = 1'b0;
        expect_sig("post_rst_tx_valid", SEL_TXV, 32'd0);
        load("rtc_after_rst", 3'b010, RTC, 32'd0);
        load("status_after_rst", 3'b010, SERIAL + 32'd4, 32'h0000_0001);
        load("ram_kept", 3'b010, BASE + 32'd8, 32'h1111_1111);
        tx_ready = 1'b0;
        repeat (3) step();
        done = 1'b1;
    end

endmodule
